traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter G_T, default 4'd10, nominal green dwell in 1 s ticks.
REQ-002 Parameter Y_T, default 4'd5, nominal yellow dwell in 1 s ticks.
REQ-003 Parameter R_T, default 4'd15, nominal red dwell in 1 s ticks.
REQ-004 Parameter SCAN_DIV, default 16'd50000, sys_clk cycles per display digit slot.
REQ-005 sys_clk  in  1  sole clock; every flop SHALL be clocked on its rising edge.
REQ-006 sys_rst_p  in  1  reset, synchronous, active-high.
REQ-007 sys_clk_1s  in  1  1 s reference level from the controller, sampled in the sys_clk domain.
REQ-008 light_ctrl  in  3  lamp code from the controller: 001 green, 010 yellow, 100 red, 000 idle.
REQ-009 light_t  in  4  remaining-seconds count from the controller, 0..15.
REQ-010 clr_err  in  1  one-cycle pulse; clears the sticky error flags.
REQ-011 seg  out  7  segment drive, active-high, bit order gfedcba.
REQ-012 an  out  2  digit select, active-low; an[1] tens, an[0] ones.
REQ-013 phase  out  2  decoded phase: 0 idle, 1 green, 2 yellow, 3 red.
REQ-014 err_seq / err_time / err_code  out  1 each  sticky flags: illegal transition / wrong dwell / non-one-hot code.

Function
REQ-015 light_ctrl and light_t SHALL be registered once; all decoding SHALL use the registered copies, one cycle of latency.
REQ-016 sys_clk_1s SHALL pass through a two-flop synchroniser; a tick SHALL be one sys_clk pulse on its synchronised rising edge.
REQ-017 phase SHALL follow registered light_ctrl: 000 idle, 001 green, 010 yellow, 100 red; any other code SHALL set err_code and leave phase unchanged.
REQ-018 Display: tens = 1 when light_t >= 10, else 0; ones = light_t - 10*tens; a tens digit of 0 SHALL be blanked (seg = 0).
REQ-019 In the idle phase both digits SHALL show "-" (seg = 7'b1000000).
REQ-020 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, the active digit SHALL toggle; exactly one an bit SHALL be low at any time.
REQ-021 Checker FSM states CHK_IDLE, CHK_G, CHK_Y, CHK_R, CHK_ERR; CHK_IDLE->CHK_G, CHK_G->CHK_Y, CHK_Y->CHK_R and CHK_R->CHK_G SHALL be legal on a phase change.
REQ-022 Any other phase change SHALL set err_seq and enter CHK_ERR; CHK_ERR SHALL resynchronise to CHK_G on the next entry into the green phase, without checking that transition.
REQ-023 A 4-bit dwell counter SHALL clear on every phase change and increment on each tick, saturating at 15.
REQ-024 On leaving a checked green, yellow or red phase, the dwell counter SHALL equal G_T, Y_T or R_T respectively; otherwise err_time SHALL be set. Dwell is not checked when leaving the idle phase, or after CHK_ERR until the next green entry.
REQ-025 A phase change and a tick in the same cycle SHALL first evaluate the old dwell count, then clear the counter (that tick is not counted).
REQ-026 Error flags SHALL remain set until clr_err or reset; when clr_err coincides with a new error, the flag SHALL end the cycle set.

Reset
REQ-027 While sys_rst_p is high: seg = 0, an = 2'b11, phase = 0, all error flags 0, FSM = CHK_IDLE, scan, dwell and synchroniser flops 0, digit select = ones.
REQ-028 Reset asserted mid-phase SHALL abandon the dwell check in progress; no error SHALL be raised by the first phase change after reset.

Configuration
REQ-029 Macro TL_MON_CHECK_EN: when defined, the checker FSM, dwell counter, err_seq and err_time SHALL be built as specified.
REQ-030 Without TL_MON_CHECK_EN, err_seq and err_time SHALL be tied to 0, and the checker and dwell logic SHALL be absent; the display, phase output and err_code SHALL remain unchanged.

Structure
REQ-031 Package traffic_light_pkg SHALL hold the light_ctrl codes, the phase encodings, the checker state encodings and the 7-segment constant table.
REQ-032 A sub-module seg7_decode (4-bit value plus blank in, 7-bit seg out, combinational) SHALL be instantiated once, on the muxed digit.

Verification
REQ-033 Green 10 ticks, then yellow 5, then red 15, then green -> no error flags; phase sequence 1, 2, 3, 1.
REQ-034 Green directly to red -> err_seq = 1 two cycles after the light_ctrl change; cleared by a clr_err pulse.
REQ-035 Green held for 9 ticks, then yellow -> err_time = 1; with TL_MON_CHECK_EN undefined -> err_time stays 0.
REQ-036 light_ctrl = 011 -> err_code = 1 and phase held; light_t = 13 -> tens digit seg = 0000110 and ones digit seg = 1001111, alternating every SCAN_DIV cycles.
REQ-037 sys_rst_p pulsed mid-red, then controller restarts from idle -> all outputs at reset values and no error flags afterwards.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared encodings for the traffic-light monitor: lamp codes, phases,
// checker FSM states and the 7-segment digit table.
// Latency: n/a (constants and one pure helper function).
// Backpressure: n/a.
package traffic_light_pkg;

    // Lamp codes driven by the controller on light_ctrl.
    localparam logic [2:0] LC_IDLE   = 3'b000;
    localparam logic [2:0] LC_GREEN  = 3'b001;
    localparam logic [2:0] LC_YELLOW = 3'b010;
    localparam logic [2:0] LC_RED    = 3'b100;

    // Decoded phase as presented on the phase output.
    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_RED    = 2'd3
    } phase_t;

    // Sequence/dwell checker states.
    typedef enum logic [2:0] {
        CHK_IDLE = 3'd0,
        CHK_G    = 3'd1,
        CHK_Y    = 3'd2,
        CHK_R    = 3'd3,
        CHK_ERR  = 3'd4
    } chk_state_t;

    // Segment patterns, bit order gfedcba, active-high.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    // Digit table, entry k is the pattern for decimal digit k.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

    // Values above 9 never reach the display; they decode to blank.
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        if (v <= 4'd9) begin
            return SEG_DIGITS[v];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/traffic_light_seg7_decode.sv
// Purpose: decimal digit to 7-segment pattern, with forced blanking.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   value  in  4  digit value 0..9 (larger values show blank)
//   blank  in  1  force all segments off
//   seg    out 7  segment pattern, gfedcba, active-high
module seg7_decode
    import traffic_light_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = seg_of(value);
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Purpose: watch a traffic-light controller, show its countdown on a
//          2-digit multiplexed display and flag sequence/dwell/code errors.
// Latency: inputs registered once; phase and error flags one cycle later.
// Backpressure: none; the monitor is a passive observer.
//
// Ports:
//   sys_clk     in  1  sole clock, rising edge
//   sys_rst_p   in  1  synchronous active-high reset
//   sys_clk_1s  in  1  1 s reference level (asynchronous to sys_clk)
//   light_ctrl  in  3  lamp code 001 green / 010 yellow / 100 red / 000 idle
//   light_t     in  4  remaining seconds 0..15
//   clr_err     in  1  pulse, clears sticky error flags
//   seg         out 7  segment drive gfedcba, active-high
//   an          out 2  digit select active-low, an[1] tens, an[0] ones
//   phase       out 2  0 idle, 1 green, 2 yellow, 3 red
//   err_seq / err_time / err_code  out  sticky error flags
//
// Build option: define TL_MON_CHECK_EN to include the sequence/dwell
// checker. Without it err_seq and err_time are tied low.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter logic [3:0]  G_T      = 4'd10,
    parameter logic [3:0]  Y_T      = 4'd5,
    parameter logic [3:0]  R_T      = 4'd15,
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_p,
    input  logic       sys_clk_1s,
    input  logic [2:0] light_ctrl,
    input  logic [3:0] light_t,
    input  logic       clr_err,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [1:0] phase,
    output logic       err_seq,
    output logic       err_time,
    output logic       err_code
);

    // ------------------------------------------------------------------
    // Input capture, phase decode, 1 s tick
    // ------------------------------------------------------------------
    logic [2:0]  lc_q;
    logic [3:0]  lt_q;
    phase_t      phase_q;
    phase_t      phase_nxt;
    logic        code_bad;
    logic        phase_chg;
    logic        err_code_q;
    logic [2:0]  sync_q;      // [0],[1] synchroniser, [2] edge-detect history
    logic        tick;

    // An illegal code keeps the previous phase rather than guessing one.
    always_comb begin
        phase_nxt = phase_q;
        code_bad  = 1'b0;
        case (lc_q)
            LC_IDLE:   phase_nxt = PH_IDLE;
            LC_GREEN:  phase_nxt = PH_GREEN;
            LC_YELLOW: phase_nxt = PH_YELLOW;
            LC_RED:    phase_nxt = PH_RED;
            default:   code_bad  = 1'b1;
        endcase
    end

    assign phase_chg = (phase_nxt != phase_q);
    assign tick      = sync_q[1] & ~sync_q[2];

    always_ff @(posedge sys_clk) begin
        if (sys_rst_p) begin
            lc_q       <= LC_IDLE;
            lt_q       <= 4'd0;
            phase_q    <= PH_IDLE;
            err_code_q <= 1'b0;
            sync_q     <= 3'b000;
        end else begin
            lc_q       <= light_ctrl;
            lt_q       <= light_t;
            phase_q    <= phase_nxt;
            // A fresh error wins over a coincident clear.
            err_code_q <= code_bad | (err_code_q & ~clr_err);
            sync_q     <= {sync_q[1:0], sys_clk_1s};
        end
    end

    assign phase    = phase_q;
    assign err_code = err_code_q;

    // ------------------------------------------------------------------
    // Display: digit scan and segment mux
    // ------------------------------------------------------------------
    logic [15:0] scan_cnt;
    logic        dig_sel;     // 0 = ones digit active, 1 = tens digit active
    logic        tens;
    logic [3:0]  ones;
    logic [3:0]  dig_val;
    logic        dig_blank;
    logic [6:0]  seg_dec;

    always_ff @(posedge sys_clk) begin
        if (sys_rst_p) begin
            scan_cnt <= 16'd0;
            dig_sel  <= 1'b0;
        end else if (scan_cnt == SCAN_DIV - 16'd1) begin
            scan_cnt <= 16'd0;
            dig_sel  <= ~dig_sel;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    assign tens      = (lt_q >= 4'd10);
    assign ones      = tens ? (lt_q - 4'd10) : lt_q;
    assign dig_val   = dig_sel ? {3'b000, tens} : ones;
    assign dig_blank = dig_sel & ~tens;   // leading zero suppressed

    seg7_decode u_seg7_decode (
        .value (dig_val),
        .blank (dig_blank),
        .seg   (seg_dec)
    );

    // Reset forces the display dark immediately, not only after the
    // flops have been cleared by an edge.
    always_comb begin
        seg = seg_dec;
        an  = dig_sel ? 2'b01 : 2'b10;
        if (phase_q == PH_IDLE) begin
            seg = SEG_DASH;
        end
        if (sys_rst_p) begin
            seg = SEG_BLANK;
            an  = 2'b11;
        end
    end

    // ------------------------------------------------------------------
    // Sequence and dwell checker
    // ------------------------------------------------------------------
`ifdef TL_MON_CHECK_EN
    chk_state_t chk_q;
    chk_state_t chk_nxt;
    logic [3:0] dwell_q;
    logic       seq_bad;
    logic       time_bad;
    logic       err_seq_q;
    logic       err_time_q;

    // Dwell is judged on the count before this cycle's clear, so a tick
    // landing on the phase-change cycle is dropped.
    always_comb begin
        chk_nxt  = chk_q;
        seq_bad  = 1'b0;
        time_bad = 1'b0;
        if (phase_chg) begin
            case (chk_q)
                // CHK_IDLE is only reachable through reset. The first change
                // afterwards may land mid-cycle, so a non-green entry parks
                // in CHK_ERR silently and waits for green.
                CHK_IDLE: chk_nxt = (phase_nxt == PH_GREEN) ? CHK_G : CHK_ERR;
                CHK_G: begin
                    time_bad = (dwell_q != G_T);
                    if (phase_nxt == PH_YELLOW) begin
                        chk_nxt = CHK_Y;
                    end else begin
                        seq_bad = 1'b1;
                        chk_nxt = CHK_ERR;
                    end
                end
                CHK_Y: begin
                    time_bad = (dwell_q != Y_T);
                    if (phase_nxt == PH_RED) begin
                        chk_nxt = CHK_R;
                    end else begin
                        seq_bad = 1'b1;
                        chk_nxt = CHK_ERR;
                    end
                end
                CHK_R: begin
                    time_bad = (dwell_q != R_T);
                    if (phase_nxt == PH_GREEN) begin
                        chk_nxt = CHK_G;
                    end else begin
                        seq_bad = 1'b1;
                        chk_nxt = CHK_ERR;
                    end
                end
                CHK_ERR: begin
                    if (phase_nxt == PH_GREEN) begin
                        chk_nxt = CHK_G;
                    end
                end
                default: chk_nxt = CHK_ERR;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_p) begin
            chk_q      <= CHK_IDLE;
            dwell_q    <= 4'd0;
            err_seq_q  <= 1'b0;
            err_time_q <= 1'b0;
        end else begin
            chk_q <= chk_nxt;
            if (phase_chg) begin
                dwell_q <= 4'd0;
            end else if (tick && (dwell_q != 4'd15)) begin
                dwell_q <= dwell_q + 4'd1;
            end
            err_seq_q  <= seq_bad  | (err_seq_q  & ~clr_err);
            err_time_q <= time_bad | (err_time_q & ~clr_err);
        end
    end

    assign err_seq  = err_seq_q;
    assign err_time = err_time_q;
`else
    // Checker absent: tick, phase-change and dwell limits have no consumer.
    logic unused_chk;
    assign unused_chk = ^{tick, phase_chg, G_T, Y_T, R_T};

    assign err_seq  = 1'b0;
    assign err_time = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: a display/phase vector
// table plus directed sequences for sequencing, dwell, illegal codes and
// reset. Expected err_seq/err_time follow the TL_MON_CHECK_EN build option.
module tb_traffic_light_monitor;

    localparam logic [15:0] SCAN = 16'd4;

`ifdef TL_MON_CHECK_EN
    localparam logic CHK_ON = 1'b1;
`else
    localparam logic CHK_ON = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_p = 1'b1;
    logic       sys_clk_1s = 1'b0;
    logic [2:0] light_ctrl = 3'b000;
    logic [3:0] light_t = 4'd0;
    logic       clr_err = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic [1:0] phase;
    logic       err_seq;
    logic       err_time;
    logic       err_code;

    int n_pass  = 0;
    int n_total = 0;

    traffic_light_monitor #(
        .G_T      (4'd10),
        .Y_T      (4'd5),
        .R_T      (4'd15),
        .SCAN_DIV (SCAN)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_p  (sys_rst_p),
        .sys_clk_1s (sys_clk_1s),
        .light_ctrl (light_ctrl),
        .light_t    (light_t),
        .clr_err    (clr_err),
        .seg        (seg),
        .an         (an),
        .phase      (phase),
        .err_seq    (err_seq),
        .err_time   (err_time),
        .err_code   (err_code)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [2:0] lc;
        logic [3:0] lt;
        logic [1:0] ph;
        logic [6:0] ones;
        logic [6:0] tens;
    } vec_t;

    vec_t vt [11];

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bounded wait for a given digit select; the caller checks an afterwards.
    task automatic wait_an(input logic [1:0] tgt);
        for (int i = 0; i < 24; i++) begin
            if (an === tgt) break;
            cyc(1);
        end
    endtask

    task automatic one_tick();
        sys_clk_1s = 1'b1;
        cyc(3);
        sys_clk_1s = 1'b0;
        cyc(3);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) one_tick();
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
    endtask

    task automatic check_digits(input string name, input logic [6:0] exp_ones, input logic [6:0] exp_tens);
        wait_an(2'b10);
        check({name, "_an_ones"}, 32'(an), 32'(2'b10));
        check({name, "_seg_ones"}, 32'(seg), 32'(exp_ones));
        wait_an(2'b01);
        check({name, "_an_tens"}, 32'(an), 32'(2'b01));
        check({name, "_seg_tens"}, 32'(seg), 32'(exp_tens));
    endtask

    initial begin
        int slot;

        vt[0]  = '{3'b000, 4'd5,  2'd0, 7'b1000000, 7'b1000000};
        vt[1]  = '{3'b001, 4'd13, 2'd1, 7'b1001111, 7'b0000110};
        vt[2]  = '{3'b010, 4'd7,  2'd2, 7'b0000111, 7'b0000000};
        vt[3]  = '{3'b100, 4'd15, 2'd3, 7'b1101101, 7'b0000110};
        vt[4]  = '{3'b001, 4'd10, 2'd1, 7'b0111111, 7'b0000110};
        vt[5]  = '{3'b001, 4'd9,  2'd1, 7'b1101111, 7'b0000000};
        vt[6]  = '{3'b011, 4'd4,  2'd1, 7'b1100110, 7'b0000000};
        vt[7]  = '{3'b001, 4'd0,  2'd1, 7'b0111111, 7'b0000000};
        vt[8]  = '{3'b010, 4'd2,  2'd2, 7'b1011011, 7'b0000000};
        vt[9]  = '{3'b100, 4'd8,  2'd3, 7'b1111111, 7'b0000000};
        vt[10] = '{3'b000, 4'd11, 2'd0, 7'b1000000, 7'b1000000};

        // Reset state
        cyc(2);
        check("rst_seg", 32'(seg), 32'(7'b0000000));
        check("rst_an", 32'(an), 32'(2'b11));
        check("rst_phase", 32'(phase), 32'(2'd0));
        check("rst_err_seq", 32'(err_seq), 32'(1'b0));
        check("rst_err_time", 32'(err_time), 32'(1'b0));
        check("rst_err_code", 32'(err_code), 32'(1'b0));
        sys_rst_p = 1'b0;
        cyc(2);

        // Display / phase table
        for (int i = 0; i < 11; i++) begin
            light_ctrl = vt[i].lc;
            light_t    = vt[i].lt;
            cyc(3);
            check($sformatf("vec%0d_phase", i), 32'(phase), 32'(vt[i].ph));
            check_digits($sformatf("vec%0d", i), vt[i].ones, vt[i].tens);
        end

        // Clean restart
        sys_rst_p = 1'b1;
        light_ctrl = 3'b000;
        cyc(2);
        sys_rst_p = 1'b0;
        cyc(2);

        // Full legal cycle with nominal dwells
        light_ctrl = 3'b001; cyc(3);
        check("cyc_phase_g", 32'(phase), 32'(2'd1));
        ticks(10);
        light_ctrl = 3'b010; cyc(3);
        check("cyc_phase_y", 32'(phase), 32'(2'd2));
        ticks(5);
        light_ctrl = 3'b100; cyc(3);
        check("cyc_phase_r", 32'(phase), 32'(2'd3));
        ticks(15);
        light_ctrl = 3'b001; cyc(3);
        check("cyc_phase_g2", 32'(phase), 32'(2'd1));
        check("cyc_err_seq", 32'(err_seq), 32'(1'b0));
        check("cyc_err_time", 32'(err_time), 32'(1'b0));
        check("cyc_err_code", 32'(err_code), 32'(1'b0));

        // Green straight to red: err_seq two cycles after the change
        ticks(10);
        light_ctrl = 3'b100;
        cyc(1);
        check("skip_err_seq_1cyc", 32'(err_seq), 32'(1'b0));
        cyc(1);
        check("skip_err_seq_2cyc", 32'(err_seq), 32'(CHK_ON));
        check("skip_err_time", 32'(err_time), 32'(1'b0));
        cyc(2);
        pulse_clr();
        check("skip_err_seq_clr", 32'(err_seq), 32'(1'b0));

        // Short green (9 ticks), re-entered from the error state
        light_ctrl = 3'b001; cyc(3);
        check("short_resync_err_seq", 32'(err_seq), 32'(1'b0));
        ticks(9);
        light_ctrl = 3'b010; cyc(3);
        check("short_err_time", 32'(err_time), 32'(CHK_ON));
        check("short_err_seq", 32'(err_seq), 32'(1'b0));
        pulse_clr();
        check("short_err_time_clr", 32'(err_time), 32'(1'b0));

        // Illegal code: phase held, err_code set, clear loses to new error
        light_ctrl = 3'b011;
        light_t    = 4'd13;
        cyc(3);
        check("bad_err_code", 32'(err_code), 32'(1'b1));
        check("bad_phase_held", 32'(phase), 32'(2'd2));
        pulse_clr();
        check("bad_clr_coincide", 32'(err_code), 32'(1'b1));
        check_digits("bad13", 7'b1001111, 7'b0000110);
        wait_an(2'b01);
        wait_an(2'b10);
        slot = 0;
        while (an === 2'b10 && slot < 20) begin
            cyc(1);
            slot++;
        end
        check("scan_slot_len", 32'(slot), 32'(SCAN));
        light_ctrl = 3'b010; cyc(3);
        pulse_clr();
        check("bad_err_code_clr", 32'(err_code), 32'(1'b0));
        check("bad_err_seq_none", 32'(err_seq), 32'(1'b0));

        // Reset mid-red, controller restarts from idle
        ticks(5);
        light_ctrl = 3'b100; cyc(3);
        check("pre_rst_phase_r", 32'(phase), 32'(2'd3));
        check("pre_rst_err_time", 32'(err_time), 32'(1'b0));
        ticks(3);
        sys_rst_p  = 1'b1;
        light_ctrl = 3'b000;
        cyc(2);
        check("mid_rst_seg", 32'(seg), 32'(7'b0000000));
        check("mid_rst_an", 32'(an), 32'(2'b11));
        check("mid_rst_phase", 32'(phase), 32'(2'd0));
        sys_rst_p = 1'b0;
        cyc(3);
        check("post_rst_phase", 32'(phase), 32'(2'd0));
        check("post_rst_seg_dash", 32'(seg), 32'(7'b1000000));
        light_ctrl = 3'b001; cyc(3);
        check("post_rst_phase_g", 32'(phase), 32'(2'd1));
        check("post_rst_err_seq", 32'(err_seq), 32'(1'b0));
        check("post_rst_err_time", 32'(err_time), 32'(1'b0));
        check("post_rst_err_code", 32'(err_code), 32'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
